// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch stage controller: issues one memory request at a time,
// holds the returned word for ID, and handles redirects and misaligned PCs.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_REQ   | inst_req asserted for pc, waiting for inst_addr_ok
// S_WAIT  | request accepted, waiting for inst_data_ok
// S_HOLD  | fetched word presented to ID until it is accepted
// S_FAULT | misaligned pc presented to ID as an address fault
module if_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'hbfc00000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        id_allow_in,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic        fetch_valid,
  output logic [31:0] fetch_pc,
  output logic [31:0] fetch_inst,
  output logic        fetch_addr_fault
);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_FAULT = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        discard_q, discard_d;
  logic [31:0] inst_q, inst_d;
  logic        presenting;

  // A misaligned pc never reaches memory; it goes straight to ID as a fault.
  function automatic state_e fetch_state(input logic [31:0] pc);
    return (pc[1:0] != 2'b00) ? S_FAULT : S_REQ;
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_REQ;
      pc_q      <= RESET_PC;
      discard_q <= 1'b0;
      inst_q    <= 32'h0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      discard_q <= discard_d;
      inst_q    <= inst_d;
    end
  end

  assign presenting = (state_q == S_HOLD) || (state_q == S_FAULT);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    discard_d = discard_q;
    inst_d    = inst_q;
    unique case (state_q)
      S_REQ: begin
        if (redirect_valid) begin
          pc_d = redirect_target;
          if (inst_addr_ok) begin
            discard_d = 1'b1;
            state_d   = S_WAIT;
          end else begin
            state_d = fetch_state(redirect_target);
          end
        end else if (inst_addr_ok) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          pc_d = redirect_target;
          if (inst_data_ok) begin
            discard_d = 1'b0;
            state_d   = fetch_state(redirect_target);
          end else begin
            discard_d = 1'b1;
          end
        end else if (inst_data_ok) begin
          if (discard_q) begin
            discard_d = 1'b0;
            state_d   = fetch_state(pc_q);
          end else begin
            inst_d  = inst_rdata;
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD, S_FAULT: begin
        // Redirect wins over an ID handshake in the same cycle.
        if (redirect_valid) begin
          pc_d    = redirect_target;
          state_d = fetch_state(redirect_target);
        end else if (id_allow_in) begin
          pc_d    = pc_q + 32'd4;
          state_d = fetch_state(pc_q + 32'd4);
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  assign inst_req         = !reset && (state_q == S_REQ);
  assign inst_addr        = pc_q;
  assign fetch_valid      = !reset && presenting && !redirect_valid;
  assign fetch_pc         = pc_q;
  assign fetch_inst       = (state_q == S_FAULT) ? 32'h0 : inst_q;
  assign fetch_addr_fault = !reset && (state_q == S_FAULT);

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Scoreboard bench for if_fetch_ctrl: expected fetches are queued when data
// is returned and compared whenever the stage presents an instruction.
module tb_if_fetch_ctrl;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] fault;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        id_allow_in;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic [31:0] fetch_inst;
  logic        fetch_addr_fault;

  int   n_chk  = 0;
  int   n_pass = 0;
  exp_t sb[$];

  if_fetch_ctrl dut (
    .clock           (clock),
    .reset           (reset),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .id_allow_in     (id_allow_in),
    .inst_req        (inst_req),
    .inst_addr       (inst_addr),
    .inst_addr_ok    (inst_addr_ok),
    .inst_data_ok    (inst_data_ok),
    .inst_rdata      (inst_rdata),
    .fetch_valid     (fetch_valid),
    .fetch_pc        (fetch_pc),
    .fetch_inst      (fetch_inst),
    .fetch_addr_fault(fetch_addr_fault)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
  endtask

  // Whatever the stage presents must match the scoreboard front.
  always @(negedge clock) begin
    if (!reset && fetch_valid) begin
      if (sb.size() == 0) begin
        chk("spurious_valid", {31'b0, fetch_valid}, 32'h0);
      end else begin
        chk("sb_pc", fetch_pc, sb[0].pc);
        chk("sb_inst", fetch_inst, sb[0].inst);
        chk("sb_fault", {31'b0, fetch_addr_fault}, sb[0].fault);
        if (id_allow_in) void'(sb.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
    inst_addr_ok   = 1'b0;
    inst_data_ok   = 1'b0;
    redirect_valid = 1'b0;
    #1;
  endtask

  task automatic do_fetch(input logic [31:0] a, input logic [31:0] d);
    chk("req", {31'b0, inst_req}, 32'h1);
    chk("addr", inst_addr, a);
    inst_addr_ok = 1'b1;
    tick();
    chk("wait_noreq", {31'b0, inst_req}, 32'h0);
    tick();
    inst_data_ok = 1'b1;
    inst_rdata   = d;
    sb.push_back('{pc: a, inst: d, fault: 32'h0});
    tick();
  endtask

  initial begin
    reset = 1'b1; redirect_valid = 1'b0; redirect_target = 32'h0;
    id_allow_in = 1'b0; inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = 32'h0;
    tick(); tick();
    chk("rst_req", {31'b0, inst_req}, 32'h0);
    chk("rst_valid", {31'b0, fetch_valid}, 32'h0);
    reset = 1'b0;
    #1;
    chk("post_rst_req", {31'b0, inst_req}, 32'h1);
    chk("post_rst_addr", inst_addr, 32'hbfc00000);

    // Basic fetch: addr_ok at cycle 1, data at cycle 3, ID ready.
    id_allow_in = 1'b1;
    tick();
    do_fetch(32'hbfc00000, 32'h24010001);
    tick();
    chk("next_addr", inst_addr, 32'hbfc00004);

    // ID stall for 5 cycles; stray data_ok in HOLD must be ignored.
    id_allow_in = 1'b0;
    do_fetch(32'hbfc00004, 32'h8c220004);
    for (int i = 0; i < 5; i++) begin
      chk("stall_noreq", {31'b0, inst_req}, 32'h0);
      chk("stall_valid", {31'b0, fetch_valid}, 32'h1);
      if (i == 2) begin inst_data_ok = 1'b1; inst_rdata = 32'hdeadbeef; end
      tick();
    end
    id_allow_in = 1'b1;
    tick();
    chk("after_stall", inst_addr, 32'hbfc00008);

    // Redirect while waiting for data: response dropped.
    inst_addr_ok = 1'b1;
    tick();
    redirect_valid = 1'b1; redirect_target = 32'h80000180;
    tick();
    chk("wait_redir_noreq", {31'b0, inst_req}, 32'h0);
    inst_data_ok = 1'b1; inst_rdata = 32'h11111111;
    tick();
    chk("wait_redir_addr", inst_addr, 32'h80000180);
    do_fetch(32'h80000180, 32'h00000180);
    tick();

    // Redirect coinciding with addr_ok.
    inst_addr_ok = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h80000010;
    tick();
    chk("req_redir_noreq", {31'b0, inst_req}, 32'h0);
    tick();
    inst_data_ok = 1'b1; inst_rdata = 32'h22222222;
    tick();
    chk("req_redir_addr", inst_addr, 32'h80000010);
    do_fetch(32'h80000010, 32'h00000010);
    tick();

    // Redirect coinciding with data_ok.
    inst_addr_ok = 1'b1;
    tick();
    inst_data_ok = 1'b1; inst_rdata = 32'h33333333;
    redirect_valid = 1'b1; redirect_target = 32'h80000020;
    tick();
    chk("data_redir_addr", inst_addr, 32'h80000020);

    // Redirect in HOLD beats the ID handshake.
    do_fetch(32'h80000020, 32'h00000020);
    redirect_valid = 1'b1; redirect_target = 32'h80000040;
    #1;
    chk("hold_redir_gate", {31'b0, fetch_valid}, 32'h0);
    void'(sb.pop_front());
    tick();
    chk("hold_redir_addr", inst_addr, 32'h80000040);

    // Misaligned redirect: fault presented, no request.
    redirect_valid = 1'b1; redirect_target = 32'h80000002;
    tick();
    chk("fault_noreq", {31'b0, inst_req}, 32'h0);
    chk("fault_flag", {31'b0, fetch_addr_fault}, 32'h1);
    chk("fault_inst", fetch_inst, 32'h0);
    sb.push_back('{pc: 32'h80000002, inst: 32'h0, fault: 32'h1});
    tick();
    id_allow_in = 1'b0;
    sb.push_back('{pc: 32'h80000006, inst: 32'h0, fault: 32'h1});
    chk("fault_again_noreq", {31'b0, inst_req}, 32'h0);
    tick();
    redirect_valid = 1'b1; redirect_target = 32'hfffffffc;
    void'(sb.pop_front());
    tick();

    // PC wrap.
    id_allow_in = 1'b1;
    do_fetch(32'hfffffffc, 32'hfffffffc);
    tick();
    chk("wrap_addr", inst_addr, 32'h00000000);

    // Reset mid-transaction: no discard afterwards.
    inst_addr_ok = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("midrst_addr", inst_addr, 32'hbfc00000);
    do_fetch(32'hbfc00000, 32'h0badf00d);
    tick(); tick();

    chk("sb_empty", sb.size(), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/if_fetch_ctrl.md
IF_FETCH_CTRL -- requirements
Module: if_fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'hbfc00000, meaning first fetch address after reset.
REQ-002 SHALL have port clock  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port redirect_valid  input  1  flush/redirect from exception or branch.
REQ-005 SHALL have port redirect_target  input  32  new fetch PC when redirect_valid=1.
REQ-006 SHALL have port id_allow_in  input  1  ID stage can accept an instruction this cycle.
REQ-007 SHALL have port inst_req  output  1  instruction memory request valid.
REQ-008 SHALL have port inst_addr  output  32  request address.
REQ-009 SHALL have port inst_addr_ok  input  1  request accepted this cycle.
REQ-010 SHALL have port inst_data_ok  input  1  read data returned this cycle.
REQ-011 SHALL have port inst_rdata  input  32  returned instruction word.
REQ-012 SHALL have port fetch_valid  output  1  drives if_to_id_bus valid.
REQ-013 SHALL have port fetch_pc  output  32  drives program_count and badvaddr_value.
REQ-014 SHALL have port fetch_inst  output  32  drives instruction.
REQ-015 SHALL have port fetch_addr_fault  output  1  drives exception_valid and is_address_fault; the exception code is fixed at 5'h04 (AdEL) by the stage.

Function
REQ-016 SHALL implement states REQ (inst_req=1), WAIT (request accepted, awaiting data), HOLD (instruction held for ID), FAULT (misaligned PC presented to ID).
REQ-017 SHALL keep at most one request outstanding; inst_req=0 in WAIT, HOLD and FAULT.
REQ-018 SHALL drive inst_addr = pc in every cycle.
REQ-019 SHALL enter FAULT instead of REQ whenever the next pc has pc[1:0]!=0; no memory request is issued for it; fetch_inst=0 and fetch_addr_fault=1.
REQ-020 REQ: on inst_addr_ok=1, SHALL go to WAIT next cycle; otherwise stay in REQ.
REQ-021 WAIT: on inst_data_ok=1 with discard=0, SHALL latch inst_rdata into fetch_inst and go to HOLD.
REQ-022 In HOLD or FAULT, fetch_valid SHALL be 1, gated to 0 combinationally while redirect_valid=1.
REQ-023 In HOLD or FAULT, on fetch_valid=1 and id_allow_in=1, SHALL set pc<=pc+4 (mod 2^32) and go to REQ, or to FAULT if misaligned; otherwise hold all outputs stable.
REQ-024 Redirect in REQ without inst_addr_ok: SHALL set pc<=redirect_target and stay in REQ; the address changes next cycle.
REQ-025 Redirect in REQ with inst_addr_ok in the same cycle: SHALL set pc<=redirect_target, set discard=1 and go to WAIT.
REQ-026 Redirect in WAIT without inst_data_ok: SHALL set pc<=redirect_target and discard=1, and stay in WAIT.
REQ-027 Redirect in WAIT with inst_data_ok in the same cycle: SHALL drop the data, set pc<=redirect_target and go to REQ (FAULT if misaligned), with discard=0.
REQ-028 WAIT with discard=1 on inst_data_ok: SHALL drop the data, clear discard and go to REQ (FAULT if misaligned) using the redirected pc.
REQ-029 Redirect in HOLD or FAULT: SHALL drop the held instruction, set pc<=redirect_target and go to REQ/FAULT; redirect SHALL take priority over an ID handshake in the same cycle.
REQ-030 Successive redirects SHALL each overwrite pc; the last redirect wins; discard is a single flag because only one response can be outstanding.
REQ-031 SHALL ignore inst_data_ok outside WAIT.

Reset
REQ-032 While reset=1: state<=REQ, pc<=RESET_PC, discard<=0, fetch_inst<=0.
REQ-033 Outputs SHALL be inst_req=0 and fetch_valid=0 during the reset cycle; inst_req=1 with inst_addr=RESET_PC in the first cycle after reset deasserts.
REQ-034 Reset mid-transaction SHALL abandon any outstanding request; the memory side is reset in the same cycle, so no discard is needed.

Verification
REQ-035 Reset release, addr_ok at cycle 1, data_ok=32'h24010001 at cycle 3, id_allow_in=1 -> fetch_valid=1, fetch_pc=bfc00000; next inst_addr=bfc00004.
REQ-036 id_allow_in=0 for 5 cycles in HOLD -> fetch_valid, fetch_pc and fetch_inst stable, inst_req=0 throughout.
REQ-037 Redirect to 80000180 in WAIT, then data_ok -> data dropped, fetch_valid never 1 for it, next inst_addr=80000180.
REQ-038 Redirect to 80000010 with addr_ok in the same cycle -> the following data_ok is discarded, then inst_addr=80000010.
REQ-039 Redirect to 80000002 -> no inst_req, fetch_valid=1, fetch_addr_fault=1, fetch_pc=80000002, fetch_inst=0.
REQ-040 pc=fffffffc, accepted by ID -> next inst_addr=00000000.
